branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor and branch target buffer (BTB) for the five-stage MIPS core.
- Sits upstream of the IF stage and is looked up combinationally with the current PC every cycle.
- Supplies the predicted next PC and a prediction bit; the prediction bit travels down the pipeline with the instruction.
- The ID stage resolves beq/bne/j and returns the outcome here. The block updates its table and flags a mispredict so IF can redirect and flush.

Parameters:
- IDX_W, 4, index width; table holds 2**IDX_W entries.
- CNT_W, 16, width of the lookup and mispredict statistics counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  input  32  IF-stage PC to look up.
- pred_taken  output  1  predicted taken for pc.
- pred_hit  output  1  BTB hit for pc.
- pred_npc  output  32  predicted next PC.
- hold  input  1  pipeline stall (stall_s1_s2); suppresses update and lookup counting.
- clear  input  1  synchronous invalidate of all entries.
- upd_valid  input  1  ID-stage instruction is a resolved branch/jump.
- upd_pc  input  32  PC of the resolving instruction.
- upd_taken  input  1  actual outcome (jumps always 1).
- upd_target  input  32  actual target (baddr_s2 or jaddr_s2).
- upd_pred_taken  input  1  prediction carried with the instruction.
- upd_pred_npc  input  32  predicted next PC carried with the instruction.
- mispredict  output  1  resolution disagrees with prediction.
- redirect_pc  output  32  correct next PC when mispredict=1.
- lookup_cnt  output  CNT_W  lookups performed.
- mispredict_cnt  output  CNT_W  mispredicts detected.

Behaviour:
- Entry format: valid(1), tag(30-IDX_W), target[31:2](30), ctr(2). Target bits [1:0] are always 0.
- Addressing:
  - index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
  - upd_pc uses the same index/tag split.
- Lookup (combinational, sees pre-edge table contents):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_npc = pred_taken ? {target,2'b00} : pc+4. The 32-bit add wraps modulo 2^32.
- Update: happens on the edge when upd_valid & ~hold & ~clear.
  - Hit on upd_pc:
    - taken: ctr increments, saturating at 3; target overwritten with upd_target.
    - not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate the entry (overwriting any occupant): valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no table change.
- mispredict (combinational) = upd_valid & ~hold & ((upd_taken ? upd_target : upd_pc+4) != upd_pred_npc).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. Valid only while mispredict=1.
- Statistics (both wrap at 2**CNT_W):
  - lookup_cnt increments on each edge with ~hold.
  - mispredict_cnt increments on each edge with mispredict=1.
- Simultaneous lookup and update to the same index in one cycle: lookup returns old contents; the new contents are visible from the next cycle.
- clear:
  - All valid bits go to 0 and all ctr go to 2'b01 on the edge.
  - Overrides a same-cycle update.
  - Statistics counters are unaffected.
- reset (asynchronous, active-high): all valid=0, ctr=2'b01, targets/tags=0, lookup_cnt=0, mispredict_cnt=0.
- Outputs during reset:
  - pred_hit=0, pred_taken=0, pred_npc=pc+4.
  - mispredict and redirect_pc follow the upd_* inputs combinationally.
- Reset mid-update: the table is cleared immediately; the pending update is lost.
- Implementation: register-array table with no SRAM macro; no internal latency beyond the one-edge write.

Test Plan:
1. Reset, then lookup pc=0x40 -> pred_hit=0, pred_taken=0, pred_npc=0x44; lookup_cnt counts 1 per cycle.
2. Update upd_pc=0x40, taken=1, target=0x80, pred_npc=0x44 -> mispredict=1, redirect_pc=0x80 that cycle. Next cycle lookup 0x40 -> hit, taken, pred_npc=0x80; mispredict_cnt=1.
3. Counter hysteresis on 0x40:
   - Two not-taken updates -> ctr goes 2->1->0; lookup then gives pred_taken=0, pred_npc=0x44.
   - Three taken updates -> ctr saturates at 3.
   - One not-taken update -> ctr=2, still predicts taken.
4. Aliasing: allocate 0x40 (taken), then update 0x40+(4<<IDX_W)=0x80 taken, target=0x100 -> lookup 0x40 misses and 0x80 hits with target 0x100.
5. hold=1 with upd_valid=1 taken on a new pc -> no allocation, mispredict=0, lookup_cnt frozen. hold=0 on the next cycle -> update applies once only.
6. Simultaneous cases:
   - clear and update in the same cycle -> all entries invalid afterwards.
   - Assert reset asynchronously between edges -> outputs drop to the reset values without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor with branch target buffer for the five-stage MIPS
//   core. The table is looked up combinationally with the IF-stage PC every
//   cycle. The ID stage resolves branches and jumps and feeds the outcome back
//   here, which trains the table and flags a mispredict so IF can redirect.
//
// Ports
//   clk             clock, all state updates on rising edge
//   reset           asynchronous, active-high reset
//   pc              IF-stage PC to look up
//   pred_taken      predicted taken for pc
//   pred_hit        BTB hit for pc
//   pred_npc        predicted next PC
//   hold            pipeline stall; suppresses update and lookup counting
//   clear           synchronous invalidate of all entries
//   upd_valid       ID-stage instruction is a resolved branch/jump
//   upd_pc          PC of the resolving instruction
//   upd_taken       actual outcome (jumps always 1)
//   upd_target      actual target
//   upd_pred_taken  prediction carried with the instruction
//   upd_pred_npc    predicted next PC carried with the instruction
//   mispredict      resolution disagrees with prediction
//   redirect_pc     correct next PC, meaningful while mispredict=1
//   lookup_cnt      lookups performed (wraps)
//   mispredict_cnt  mispredicts detected (wraps)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  output logic             pred_taken,
  output logic             pred_hit,
  output logic [31:0]      pred_npc,
  input  logic             hold,
  input  logic             clear,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_npc,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] lookup_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  // Table storage: one register per field per entry.
  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [29:0]      tgt_q   [N];
  logic [1:0]       ctr_q   [N];

  logic [IDX_W-1:0] idx, upd_idx;
  logic [TAG_W-1:0] tag, upd_tag;
  logic             upd_hit;
  logic             upd_en;

  // Mispredict detection compares next PCs only; the carried prediction bit
  // is implied by upd_pred_npc and needs no separate check.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign idx     = pc[IDX_W+1:2];
  assign tag     = pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Lookup sees the pre-edge table, so a same-cycle update to the same entry
  // only becomes visible on the following cycle.
  assign pred_hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign pred_taken = pred_hit && ctr_q[idx][1];
  assign pred_npc   = pred_taken ? {tgt_q[idx], 2'b00} : pc + 32'd4;

  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en      = upd_valid && !hold && !clear;
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  assign mispredict  = upd_valid && !hold && (redirect_pc != upd_pred_npc);

  // NOTE: the table is reset explicitly because the predictor must start
  // cold and deterministic; this is only affordable because it is a small
  // flop array rather than an SRAM. Sequential state uses non-blocking
  // assignments so every entry updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (clear) begin
      // Invalidate wins over any update arriving in the same cycle.
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          tgt_q[upd_idx] <= upd_target[31:2];
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate weakly-taken, evicting whatever aliased into this slot.
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target[31:2];
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

  // Statistics are independent of clear and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookup_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (!hold)      lookup_cnt     <= lookup_cnt + CNT_W'(1);
      if (mispredict) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed self-checking bench for branch_predictor. Inputs change 1 time
//   unit after a rising edge; outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_npc;
  logic        hold, clear;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] lookup_cnt, mispredict_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_lcnt = 0;
  int exp_mcnt = 0;

  branch_predictor #(.IDX_W(4), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_hit       (pred_hit),
    .pred_npc       (pred_npc),
    .hold           (hold),
    .clear          (clear),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_npc   (upd_pred_npc),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .lookup_cnt     (lookup_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one clock; the bench tracks the expected lookup count itself.
  task automatic tick();
    if (!hold && !reset) exp_lcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] pnpc);
    upd_valid      = 1'b1;
    upd_pc         = p;
    upd_taken      = t;
    upd_target     = tgt;
    upd_pred_taken = pt;
    upd_pred_npc   = pnpc;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] p, input logic hit,
                      input logic tk, input logic [31:0] npc);
    pc = p;
    #1;
    check({tag, ".hit"},   {31'd0, pred_hit},   {31'd0, hit});
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
    check({tag, ".npc"},   pred_npc,            npc);
  endtask

  task automatic counters(input string tag);
    check({tag, ".lookup_cnt"},     {16'd0, lookup_cnt},     32'(exp_lcnt));
    check({tag, ".mispredict_cnt"}, {16'd0, mispredict_cnt}, 32'(exp_mcnt));
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; clear = 1'b0; pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_npc = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    counters("rst");
    reset = 1'b0;

    // 1: cold lookup, lookup counting, PC+4 wrap
    look("cold", 32'h40, 1'b0, 1'b0, 32'h44);
    tick(); tick();
    counters("cold");
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // 2: first taken resolution allocates and mispredicts
    pc = 32'h40;
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    #1;
    check("alloc.mispredict", {31'd0, mispredict}, 32'd1);
    check("alloc.redirect",   redirect_pc,         32'h80);
    look("alloc.same_cycle", 32'h40, 1'b0, 1'b0, 32'h44);
    tick(); exp_mcnt++; idle();
    look("alloc.next", 32'h40, 1'b1, 1'b1, 32'h80);
    counters("alloc");

    // 3: hysteresis, ctr 2 -> 1 -> 0 then up to saturation
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h44);   // correctly redirected: no mispredict
    #1; check("nt1.mispredict", {31'd0, mispredict}, 32'd0);
    tick(); idle();
    look("ctr1", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    tick(); idle();
    look("ctr0", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h80);  // 0 -> 1
    tick();
    look("ctr1_up", 32'h40, 1'b1, 1'b0, 32'h44);
    tick();                                    // 1 -> 2
    tick();                                    // 2 -> 3
    upd(32'h40, 1'b1, 32'h90, 1'b1, 32'h80);  // 3 saturates, target moves to 0x90
    #1;
    check("retarget.mispredict", {31'd0, mispredict}, 32'd1);
    check("retarget.redirect",   redirect_pc,         32'h90);
    tick(); exp_mcnt++;
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h44);   // 3 -> 2, still taken
    tick(); idle();
    look("ctr2_after_sat", 32'h40, 1'b1, 1'b1, 32'h90);
    counters("hyst");

    // 4: aliasing, 0x80 shares index 0 with 0x40
    upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    tick(); exp_mcnt++; idle();
    look("alias.old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias.new", 32'h80, 1'b1, 1'b1, 32'h100);

    // 5: hold blocks update, mispredict and lookup counting
    hold = 1'b1;
    upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    #1; check("hold.mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    counters("hold");
    look("hold.no_alloc", 32'h200, 1'b0, 1'b0, 32'h204);
    hold = 1'b0;
    #1; check("unhold.mispredict", {31'd0, mispredict}, 32'd1);
    tick(); exp_mcnt++; idle();
    look("unhold.alloc", 32'h200, 1'b1, 1'b1, 32'h300);
    upd(32'h200, 1'b0, 32'h0, 1'b1, 32'h204); // single alloc: ctr 2 -> 1
    tick(); idle();
    look("unhold.once", 32'h200, 1'b1, 1'b0, 32'h204);
    counters("unhold");

    // 6a: clear beats a same-cycle update, statistics untouched
    clear = 1'b1;
    upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
    #1; check("clear.mispredict", {31'd0, mispredict}, 32'd1);
    tick(); exp_mcnt++; idle(); clear = 1'b0;
    look("clear.upd",   32'h300, 1'b0, 1'b0, 32'h304);
    look("clear.alias", 32'h80,  1'b0, 1'b0, 32'h84);
    look("clear.other", 32'h200, 1'b0, 1'b0, 32'h204);
    counters("clear");

    // 6b: asynchronous reset between edges
    upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h100);
    tick(); idle();
    look("pre_async", 32'h80, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    #1 reset = 1'b1;
    exp_lcnt = 0; exp_mcnt = 0;
    look("async", 32'h80, 1'b0, 1'b0, 32'h84);
    counters("async");
    check("async.mispredict", {31'd0, mispredict}, 32'd1);
    check("async.redirect",   redirect_pc,         32'h44);
    tick(); idle();
    counters("async_held");
    reset = 1'b0;
    look("post_reset", 32'h80, 1'b0, 1'b0, 32'h84);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
